// File: rtl/maxpool_stage.sv
// ---------------------------------------------------------------------------
// maxpool_stage
// 2x2 / stride-2 max pooling over a raster-order feature-map stream (one
// channel). Even rows are reduced pairwise into a half-width line buffer.
// Odd rows are reduced pairwise and combined with the line buffer to form one
// pooled pixel per 2x2 window. That pixel is held in a single-entry output
// register. A trailing odd column or odd row is accepted and dropped.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous active-high reset
//   in_valid   upstream pixel valid
//   in_ready   block can accept a pixel (combinational)
//   in_pixel   upstream pixel, row-major, col 0 first
//   out_valid  pooled pixel valid (registered)
//   out_ready  downstream accepts pooled pixel
//   out_pixel  pooled pixel (registered)
//   frame_done one-cycle pulse after the last input pixel of a frame
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_EVEN | top row of a pooling window; pair maxima go to the line buffer
// S_ODD  | bottom row of a window; pair max + line buffer -> output
// S_SKIP | trailing row of an odd-height map; beats accepted and dropped
// ---------------------------------------------------------------------------
module maxpool_stage #(
    parameter int IMG_W  = 225,
    parameter int IMG_H  = 225,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              frame_done
);

    localparam int PW  = IMG_W / 2;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBW = (PW > 1) ? $clog2(PW) : 1;

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_PRE_SKIP = RW'(IMG_H - 2);
    localparam bit            W_ODD        = (IMG_W % 2) == 1;
    localparam bit            H_ODD        = (IMG_H % 2) == 1;

    typedef enum logic [1:0] {
        S_EVEN = 2'd0,
        S_ODD  = 2'd1,
        S_SKIP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
    logic              frame_done_q, frame_done_d;

    logic [DATA_W-1:0] linebuf [PW];
    logic [LBW-1:0]    lb_idx;
    logic [DATA_W-1:0] lb_rd;
    logic              lb_we;

    logic accept;
    logic last_col;
    logic last_row;
    logic col_odd;
    logic col_pool;

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    // Ready depends only on whether the output slot will be free; it does
    // not depend on position, so skipped pixels are throttled the same way.
    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_col   = (col_q == COL_LAST);
    assign last_row   = (row_q == ROW_LAST);
    assign col_odd    = col_q[0];
    // Only the trailing column of an odd-width map falls outside a window.
    assign col_pool   = !(W_ODD && last_col);
    assign lb_idx     = LBW'(col_q >> 1);
    assign lb_rd      = linebuf[lb_idx];
    assign lb_we      = accept && (state_q == S_EVEN) && col_odd;

    assign out_valid  = out_valid_q;
    assign out_pixel  = out_pixel_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_pixel_d  = out_pixel_q;
        frame_done_d = 1'b0;
        // A taken output empties the slot unless a new result lands this cycle.
        out_valid_d  = out_valid_q && !out_ready;

        if (accept) begin
            col_d = last_col ? '0 : col_q + CW'(1);
            if (last_col) begin
                row_d        = last_row ? '0 : row_q + RW'(1);
                frame_done_d = last_row;
            end

            unique case (state_q)
                S_EVEN: begin
                    if (!col_odd && col_pool) begin
                        hold_d = in_pixel;
                    end
                    if (last_col) begin
                        state_d = S_ODD;
                    end
                end
                S_ODD: begin
                    if (!col_odd && col_pool) begin
                        hold_d = in_pixel;
                    end else if (col_odd) begin
                        out_pixel_d = max2(max2(hold_q, in_pixel), lb_rd);
                        out_valid_d = 1'b1;
                    end
                    if (last_col) begin
                        if (last_row) begin
                            state_d = S_EVEN;
                        end else if (H_ODD && (row_q == ROW_PRE_SKIP)) begin
                            state_d = S_SKIP;
                        end else begin
                            state_d = S_EVEN;
                        end
                    end
                end
                S_SKIP: begin
                    if (last_col) begin
                        state_d = S_EVEN;
                    end
                end
                default: begin
                    state_d = S_EVEN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line buffer is always written on the even row before the odd row reads
    // it, so it carries no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= max2(hold_q, in_pixel);
        end
    end

endmodule

// File: tb/tb_maxpool_stage.sv
module tb_maxpool_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       in_valid   [3];
    logic       in_ready   [3];
    logic       out_valid  [3];
    logic       out_ready  [3];
    logic       frame_done [3];
    logic [7:0] in_pixel   [3];
    logic [7:0] out_pixel  [3];

    logic       drv_last   [3];
    bit         rnd_rdy    [3];
    logic [7:0] exp_q      [3][$];
    int         dim_w      [3] = '{4, 5, 2};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : (g == 1) ? 5 : 2;
        maxpool_stage #(.IMG_W(W), .IMG_H(W), .DATA_W(8)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_pixel  (in_pixel[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_pixel (out_pixel[g]),
            .frame_done(frame_done[g])
        );
    end

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: every complete 2x2 window in raster order, maximum of four.
    function automatic void model_push(input int d, input int w, input int h,
                                       input logic [7:0] pix[$]);
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                logic [7:0] m;
                m = pix[(2*r)*w + 2*c];
                if (pix[(2*r)*w + 2*c + 1] > m)   m = pix[(2*r)*w + 2*c + 1];
                if (pix[(2*r+1)*w + 2*c] > m)     m = pix[(2*r+1)*w + 2*c];
                if (pix[(2*r+1)*w + 2*c + 1] > m) m = pix[(2*r+1)*w + 2*c + 1];
                exp_q[d].push_back(m);
            end
        end
    endfunction

    function automatic void ramp(output logic [7:0] q[$], input int start, input int n);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'(start + i));
    endfunction

    function automatic void rand_frame(output logic [7:0] q[$], input int n);
        q = {};
        for (int i = 0; i < n; i++)
            q.push_back(($urandom_range(0, 4) == 0) ? 8'd200 : 8'($urandom));
    endfunction

    // Called at a falling edge; returns at a falling edge.
    task automatic send_frame(input int d, input logic [7:0] pix[$], input int n_send,
                              input bit gaps);
        int w;
        int total;
        int waited;
        w     = dim_w[d];
        total = w * w;
        if (n_send == total) model_push(d, w, w, pix);
        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                in_valid[d] = 1'b0;
                drv_last[d] = 1'b0;
                while ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            in_valid[d] = 1'b1;
            in_pixel[d] = pix[i];
            drv_last[d] = (n_send == total) && (i == total - 1);
            #1;
            waited = 0;
            while (!in_ready[d] && waited < 300) begin
                @(negedge clk);
                #1;
                waited++;
            end
            if (!in_ready[d]) begin
                chk(1'b0, "in_ready_timeout", 0, 1);
                in_valid[d] = 1'b0;
                drv_last[d] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid[d] = 1'b0;
        drv_last[d] = 1'b0;
    endtask

    // Monitor / scoreboard.
    initial begin
        logic       fd_exp [3];
        logic       hp     [3];
        logic [7:0] pp     [3];
        logic [7:0] e;
        for (int d = 0; d < 3; d++) begin
            fd_exp[d] = 1'b0;
            hp[d]     = 1'b0;
            pp[d]     = '0;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 3; d++) begin
                if (rst) begin
                    chk(out_valid[d] == 1'b0, "rst_out_valid", int'(out_valid[d]), 0);
                    chk(out_pixel[d] == 8'd0, "rst_out_pixel", int'(out_pixel[d]), 0);
                    chk(frame_done[d] == 1'b0, "rst_frame_done", int'(frame_done[d]), 0);
                    chk(in_ready[d] == 1'b1, "rst_in_ready", int'(in_ready[d]), 1);
                    fd_exp[d] = 1'b0;
                    hp[d]     = 1'b0;
                end else begin
                    chk(frame_done[d] == fd_exp[d], "frame_done",
                        int'(frame_done[d]), int'(fd_exp[d]));
                    chk(in_ready[d] == (!out_valid[d] || out_ready[d]), "in_ready",
                        int'(in_ready[d]), int'(!out_valid[d] || out_ready[d]));
                    if (hp[d]) begin
                        chk(out_valid[d] == 1'b1, "hold_valid", int'(out_valid[d]), 1);
                        chk(out_pixel[d] == pp[d], "hold_pixel",
                            int'(out_pixel[d]), int'(pp[d]));
                    end
                    if (out_valid[d] && out_ready[d]) begin
                        if (exp_q[d].size() == 0) begin
                            chk(1'b0, "unexpected_out", int'(out_pixel[d]), -1);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk(out_pixel[d] == e, "out_pixel", int'(out_pixel[d]), int'(e));
                        end
                    end
                    fd_exp[d] = in_valid[d] && in_ready[d] && drv_last[d];
                    hp[d]     = out_valid[d] && !out_ready[d];
                    pp[d]     = out_pixel[d];
                end
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                if (rnd_rdy[d]) out_ready[d] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [7:0] q[$];
        int         budget;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            in_pixel[d]  = '0;
            out_ready[d] = 1'b1;
            drv_last[d]  = 1'b0;
            rnd_rdy[d]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 4x4 ramp, free-running output
        ramp(q, 0, 16);
        send_frame(0, q, 16, 1'b0);

        // 5x5 ramp, trailing column and row dropped
        ramp(q, 0, 25);
        send_frame(1, q, 25, 1'b0);

        // 4x4 with output stalled for 20 cycles
        repeat (3) @(negedge clk);
        out_ready[0] = 1'b0;
        ramp(q, 0, 16);
        fork
            send_frame(0, q, 16, 1'b0);
            begin
                repeat (20) @(negedge clk);
                out_ready[0] = 1'b1;
            end
        join

        // 2x2 maximum position frames
        q = '{200, 1, 2, 3};
        send_frame(2, q, 4, 1'b0);
        q = '{0, 0, 0, 255};
        send_frame(2, q, 4, 1'b0);
        q = '{9, 9, 9, 9};
        send_frame(2, q, 4, 1'b0);

        // Mid-frame reset with a pooled pixel pending
        repeat (3) @(negedge clk);
        out_ready[0] = 1'b0;
        ramp(q, 0, 16);
        send_frame(0, q, 6, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        ramp(q, 100, 16);
        send_frame(0, q, 16, 1'b0);

        // Back-to-back frames
        ramp(q, 0, 16);
        send_frame(0, q, 16, 1'b0);
        ramp(q, 16, 16);
        send_frame(0, q, 16, 1'b0);

        // Random data, random gaps, random backpressure
        repeat (3) @(negedge clk);
        rnd_rdy[0] = 1'b1;
        rnd_rdy[1] = 1'b1;
        for (int f = 0; f < 4; f++) begin
            rand_frame(q, 16);
            send_frame(0, q, 16, 1'b1);
            rand_frame(q, 25);
            send_frame(1, q, 25, 1'b1);
        end
        rnd_rdy[0] = 1'b0;
        rnd_rdy[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) out_ready[d] = 1'b1;

        budget = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk(exp_q[d].size() == 0, "drain_pending", exp_q[d].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
